// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared defaults and pointer-width helper for the staging FIFO
package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 2;
  localparam int DEFAULT_DEPTH      = 8;

  function automatic int addr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - register array with one write port and one registered read port
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int ADDR_WIDTH = addr_width(DEFAULT_DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // storage is deliberately left out of reset; the pointers define what is valid
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/test_fifo.sv
// rtl/test_fifo.sv - single-clock staging FIFO with full/empty throttling flags
module test_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  writeEN,
  input  logic                  readEN,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
);

  localparam int ADDR_WIDTH = addr_width(DEPTH);
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [ADDR_WIDTH:0] wr_ptr;
  logic [ADDR_WIDTH:0] rd_ptr;
  logic [ADDR_WIDTH:0] count;
  logic                do_wr;
  logic                do_rd;

  // a write into a full FIFO is accepted only when a read frees a slot that same edge
  assign do_rd = readEN & ~empty;
  assign do_wr = writeEN & (~full | do_rd);

  assign empty = (count == '0);
  assign full  = (count == FULL_COUNT);

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (do_wr & reset),
    .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
    .wr_data (din),
    .rd_en   (do_rd),
    .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
    .rd_data (dout)
  );

endmodule

// File: tb/tb_test_fifo.sv
// tb/tb_test_fifo.sv - scoreboard bench for the staging FIFO
module tb_test_fifo;

  localparam int DW    = 2;
  localparam int DEPTH = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic [DW-1:0] din;
  logic          writeEN;
  logic          readEN;
  logic [DW-1:0] dout;
  logic          full;
  logic          empty;

  int tests  = 0;
  int errors = 0;

  logic [DW-1:0] sb [$];
  logic [DW-1:0] exp_dout;

  test_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clock   (clock),
    .reset   (reset),
    .din     (din),
    .writeEN (writeEN),
    .readEN  (readEN),
    .dout    (dout),
    .full    (full),
    .empty   (empty)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic w, input logic [DW-1:0] wd, input logic r, input string tag);
    bit m_empty, m_full, m_rd, m_wr;
    m_empty = (sb.size() == 0);
    m_full  = (sb.size() == DEPTH);
    m_rd    = r && !m_empty;
    m_wr    = w && (!m_full || m_rd);
    if (m_rd) exp_dout = sb.pop_front();
    if (m_wr) sb.push_back(wd);
    writeEN = w;
    din     = wd;
    readEN  = r;
    @(posedge clock);
    #1;
    check({tag, ".dout"},  32'(dout),  32'(exp_dout));
    check({tag, ".empty"}, 32'(empty), 32'(sb.size() == 0));
    check({tag, ".full"},  32'(full),  32'(sb.size() == DEPTH));
  endtask

  task automatic do_reset(input int cycles);
    reset   = 1'b0;
    writeEN = 1'b1;
    readEN  = 1'b0;
    din     = 2'd3;
    repeat (cycles) @(posedge clock);
    #1;
    sb.delete();
    exp_dout = '0;
    check("rst.empty", 32'(empty), 32'd1);
    check("rst.full",  32'(full),  32'd0);
    check("rst.dout",  32'(dout),  32'd0);
    reset   = 1'b1;
    writeEN = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] ord [5];
    ord = '{2'd3, 2'd2, 2'd2, 2'd3, 2'd0};
    reset = 1'b1; din = '0; writeEN = 1'b0; readEN = 1'b0;
    exp_dout = '0;
    @(posedge clock);
    #1;

    do_reset(2);
    step(1'b0, 2'd0, 1'b0, "idle");

    for (int i = 0; i < 5; i++) step(1'b1, ord[i], 1'b0, "ord_wr");
    for (int i = 0; i < 5; i++) step(1'b0, 2'd0, 1'b1, "ord_rd");

    for (int i = 0; i < 8; i++) step(1'b1, DW'(i), 1'b0, "fill_wr");
    step(1'b1, 2'd3, 1'b0, "overflow");
    for (int i = 0; i < 8; i++) step(1'b0, 2'd0, 1'b1, "fill_rd");

    for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 1'b1, "underflow");
    step(1'b1, 2'd2, 1'b0, "uf_wr");
    step(1'b0, 2'd0, 1'b1, "uf_rd");

    for (int i = 0; i < 8; i++) step(1'b1, DW'(i + 1), 1'b0, "full_fill");
    for (int i = 0; i < 4; i++) step(1'b1, DW'(3 - i), 1'b1, "full_rw");
    for (int i = 0; i < 8; i++) step(1'b0, 2'd0, 1'b1, "full_drain");

    step(1'b1, 2'd1, 1'b1, "empty_rw");
    step(1'b0, 2'd0, 1'b1, "empty_rw_rd");

    for (int i = 0; i < 20; i++)
      step(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)), "mixed");

    while (sb.size() > 0) step(1'b0, 2'd0, 1'b1, "pre_drain");
    for (int i = 0; i < 3; i++) step(1'b1, DW'(i + 1), 1'b0, "rst_fill");
    do_reset(1);
    step(1'b0, 2'd0, 1'b1, "post_rst_rd");
    step(1'b1, 2'd0, 1'b0, "post_rst_wr");
    step(1'b0, 2'd0, 1'b1, "post_rst_rd2");
    step(1'b0, 2'd0, 1'b1, "post_rst_rd3");

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/test_fifo.md
# test_fifo

Synchronous single-clock first-in/first-out buffer for narrow data symbols, used as the generic staging buffer between PHY pipeline stages. Words written with `writeEN` are returned in the same order on `dout` when `readEN` is asserted. `full` and `empty` flags let neighbours throttle themselves. Overflowing writes and underflowing reads are dropped safely.

## Interface
- `DATA_WIDTH`, default 2: width of `din`/`dout`.
- `DEPTH`, default 8: number of storage entries; must be a power of two ≥ 2.
- `ADDR_WIDTH`, default log2(DEPTH) = 3: pointer index width (derived, not overridden).

Ports:
- `clock` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-low reset; sampled only on the rising edge of `clock`.
- `din` input DATA_WIDTH: write data.
- `writeEN` input 1: write request.
- `readEN` input 1: read request.
- `dout` output DATA_WIDTH: registered read data.
- `full` output 1: high when DEPTH entries are stored.
- `empty` output 1: high when zero entries are stored.

## Operation
- Storage is a DEPTH×DATA_WIDTH register array with write pointer `wr_ptr` and read pointer `rd_ptr`, each ADDR_WIDTH+1 bits; the MSB is a wrap bit.
- Occupancy `count` runs 0..DEPTH and is ADDR_WIDTH+1 bits.
- Effective write `do_wr` = `writeEN` & (!`full` | `do_rd`).
- Effective read `do_rd` = `readEN` & !`empty`.
- On `do_wr`: store `din` at mem[wr_ptr[ADDR_WIDTH-1:0]], then increment `wr_ptr` modulo 2·DEPTH.
- On `do_rd`: load mem[rd_ptr[ADDR_WIDTH-1:0]] into `dout`, then increment `rd_ptr`.
- `count` changes as follows:
  - +1 on write only.
  - −1 on read only.
  - Unchanged on both or neither.
- Flags:
  - `empty` = (count == 0).
  - `full` = (count == DEPTH).
  - Both are derived from registered state, so they carry no combinational path from the inputs.
- Write while full without a read: the write is ignored; memory and pointers are unchanged.
- Read while empty: the read is ignored; `dout` holds its previous value.
- Simultaneous read and write when full: both are performed; `full` stays high.
- Simultaneous read and write when empty: the write is performed and the read is ignored. `empty` falls the next cycle, and `dout` is unchanged.
- Pointer wrap: indices wrap from DEPTH−1 to 0 with no gap or duplicate.
- Reset (`reset`=0 at an edge):
  - Sets `wr_ptr`=0, `rd_ptr`=0, `count`=0, `dout`=0, `empty`=1, `full`=0.
  - Memory contents are not cleared.
  - Reset overrides any simultaneous `writeEN`/`readEN`.
  - A reset mid-operation discards all stored data.
- X on `writeEN`/`readEN` while `reset`=0 has no effect.

## Timing
- Write-to-visibility: a word written at edge N makes `empty` fall after edge N. The word can be read at edge N+1, and appears on `dout` after that edge.
- Read latency: one cycle; `dout` updates on the edge where `do_rd` is true.
- Flags update on the same edge as the pointer/count change that causes them.
- Throughput: one write and one read per cycle, sustained.
- `full` rises after the edge of the DEPTH-th unread write. `empty` rises after the edge of the read that removes the last word.

## Structure
- Shared package `fifo_pkg`:
  - Default `DATA_WIDTH`/`DEPTH` constants.
  - A `clog2`-based ADDR_WIDTH helper.
- A natural sub-module is `fifo_mem`, a simple dual-port register array with one write port and one registered read port.
- The top level holds the pointers, count, flag logic and the `do_wr`/`do_rd` qualification.

## Test plan
- **Reset:** hold `reset`=0 for 2 cycles with `writeEN`=1 -> `empty`=1, `full`=0, `dout`=0; nothing stored.
- **Ordered traffic:** after reset, write 3, 2, 2, 3, 0 on consecutive cycles, then read 5 times -> `dout` = 3, 2, 2, 3, 0 on successive cycles. `empty` is 0 during the reads and returns to 1 after the fifth read.
- **Fill and overflow:** write 8 words (0,1,2,3,0,1,2,3) -> `full`=1 after the 8th. A 9th write of 3 is ignored. 8 reads return 0,1,2,3,0,1,2,3 and `empty`=1.
- **Underflow:** from empty, assert `readEN` for 3 cycles -> `dout` holds its last value, pointers are unchanged, and a following write/read of 2 returns 2.
- **Simultaneous read/write:**
  - When full, read+write for 4 cycles -> `full` stays 1 and the oldest words are output in order.
  - When empty, read+write of 1 -> `empty`=0 next cycle and `dout` is unchanged.
- **Wrap and mid-operation reset:** run 20 mixed operations across pointer wrap, checked against a queue model. Then assert reset with 3 words stored -> `empty`=1 next cycle, and the old data is never returned.
